mips_data_lsu: RTL and testbench
================================

Name: mips_data_lsu

Overview:
CPU-side load/store initiator for the MIPS data memory port. It drives data_address/data_read/data_write/data_writedata and consumes the combinational data_readdata of the data RAM. It converts pipeline byte, half and word loads/stores into aligned word accesses, using read-modify-write for sub-word stores because the port has no byte enables. Memory lanes are stored byte-reversed: CPU byte at offset k occupies data bits [8k+7:8k].

Parameters:
ADDR_W, 32, width of addr and data_address
DATA_W, 32, word width; only 32 is supported

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
req  input  1  start request; sampled only when busy=0
op  input  4  lsu_op_t operation
addr  input  32  byte address
wdata  input  32  store data, CPU order
rt_old  input  32  old rt value, used for LWL/LWR merge
busy  output  1  high from the cycle after an accepted req through the done cycle
done  output  1  one-cycle completion pulse
err  output  1  valid with done: misaligned or illegal op
rdata  output  32  load result, valid with done
data_address  output  32  word-aligned address ({addr[31:2],2'b00}); 0 when idle
data_read  output  1  read strobe
data_write  output  1  write strobe; RAM writes on posedge
data_writedata  output  32  memory-order write word
data_readdata  input  32  combinational read data

Behaviour:
- Reset, asynchronous: state=IDLE; all outputs are 0. Reset during WR suppresses that write.
- FSM states: IDLE, RD, WR, DONE. req is accepted in IDLE, and op, addr, wdata and rt_old are latched.
  - Loads: IDLE->RD->DONE.
  - SW: IDLE->WR->DONE.
  - SB/SH: IDLE->RD->WR->DONE.
  - Error: IDLE->DONE with err=1. No data_read or data_write is ever asserted.
- Latency from the req cycle: load 2, SW 2, SB/SH 3, error 1. DONE always returns to IDLE. A req in the DONE cycle is ignored; back-to-back requests are accepted from IDLE only.
- RD: data_read=1. data_readdata is captured at the posedge into mem_q.
- WR: data_write=1 for exactly one cycle. data_writedata is held stable for that cycle.
- Lane k = addr[1:0]. cpu_word = byte-reverse(mem_q).
- Load results:
  - LB/LBU: lane k, sign- or zero-extended.
  - LH/LHU: {lane k, lane k+1}, sign- or zero-extended.
  - LW: cpu_word.
- Store data:
  - SW: data_writedata = byte-reverse(wdata).
  - SB: lane k <- wdata[7:0]; other lanes from mem_q.
  - SH: lane k <- wdata[15:8] and lane k+1 <- wdata[7:0]; other lanes from mem_q.
- Misalignment: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, gives err=1 and rdata=0.
- Unused op encodings give err=1.
- rdata holds its value until the next done. err clears at the next accepted req.

Optional Feature:
Macro MIPS_LSU_UNALIGNED_EN.
- Defined: LWL/LWR are legal at any alignment, with latency 2.
  - LWL: rdata = (cpu_word << 8k) | (rt_old & ((1<<8k)-1)).
  - LWR: rdata = (cpu_word >> 8(3-k)) | (rt_old & ~(32'hFFFFFFFF >> 8(3-k))).
- Undefined: LWL/LWR are illegal ops (err=1, latency 1, no memory access).

Decomposition:
- Package mips_lsu_pkg holds:
  - lsu_op_t encodings: LB=0, LBU=1, LH=2, LHU=3, LW=4, SB=5, SH=6, SW=7, LWL=8, LWR=9.
  - lsu_state_t.
  - Helper function byte_reverse.
- One combinational sub-module, mips_lsu_lane: inputs mem_q, op, k, wdata, rt_old; outputs load result, merged write word, err flag.

Test Plan:
- RAM prefilled with CPU word 32'hABCDEF00 everywhere; LW addr 0x10 -> done in cycle 2, rdata=32'hABCDEF00, err=0, data_address=0x10.
- LB addr 0x11 -> rdata=32'hFFFFFFCD; LBU addr 0x11 -> 32'h000000CD; LHU addr 0x12 -> 32'h0000EF00.
- SB wdata=0x7E addr 0x22 -> one RD cycle, then exactly one data_write cycle, done in cycle 3; following LW 0x20 -> 32'hABCD7E00.
- SH addr 0x13 -> done in cycle 1, err=1, data_read/data_write never high; SW addr 0x30 wdata 32'h01020304 -> LW 0x30 returns 32'h01020304.
- Reset asserted in the WR cycle of SW 0x40 wdata 0 -> outputs 0 immediately, no write; later LW 0x40 -> 32'hABCDEF00.
- LWL addr 0x05, rt_old 32'h11223344 -> 32'hCDEF0044 with MIPS_LSU_UNALIGNED_EN; err=1 without it.

Source files
------------

// File: rtl/mips_data_lsu_pkg.sv
// Shared types for the MIPS data load/store unit: operation encodings, FSM states
// and the CPU-order <-> memory-order byte reversal helper.
package mips_lsu_pkg;

    typedef enum logic [3:0] {
        LB  = 4'd0,
        LBU = 4'd1,
        LH  = 4'd2,
        LHU = 4'd3,
        LW  = 4'd4,
        SB  = 4'd5,
        SH  = 4'd6,
        SW  = 4'd7,
        LWL = 4'd8,
        LWR = 4'd9
    } lsu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    // CPU byte at offset k lives in memory bits [8k+7:8k], so offset 0 is the CPU MSB.
    function automatic logic [31:0] byte_reverse(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic is_rmw(input lsu_op_t op);
        return (op == SB) || (op == SH);
    endfunction

endpackage

// File: rtl/mips_data_lsu_if.sv
// Request-side (pipeline <-> LSU) and memory-side (LSU <-> data RAM) interfaces
// for the MIPS data load/store unit.
interface mips_lsu_req_if
    import mips_lsu_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic              req;
    lsu_op_t           op;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rt_old;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       rdata;

    modport master (
        output req, op, addr, wdata, rt_old,
        input  busy, done, err, rdata
    );

    modport slave (
        input  req, op, addr, wdata, rt_old,
        output busy, done, err, rdata
    );
endinterface

interface mips_lsu_mem_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] data_address;
    logic              data_read;
    logic              data_write;
    logic [31:0]       data_writedata;
    logic [31:0]       data_readdata;

    modport master (
        output data_address, data_read, data_write, data_writedata,
        input  data_readdata
    );

    modport slave (
        input  data_address, data_read, data_write, data_writedata,
        output data_readdata
    );
endinterface

// File: rtl/mips_data_lsu_lane.sv
// Combinational lane steering: load extraction/extension, sub-word store merge and
// legality check. MIPS_LSU_UNALIGNED_EN enables the LWL/LWR merge loads.
module mips_lsu_lane
    import mips_lsu_pkg::*;
(
    input  logic [31:0] mem_q,
    input  lsu_op_t     op,
    input  logic [1:0]  k,
    input  logic [31:0] wdata,
    input  logic [31:0] rt_old,
    output logic [31:0] load_data,
    output logic [31:0] store_data,
    output logic        err
);
    logic [7:0]  lane [4];
    logic [7:0]  sel_b;
    logic [7:0]  sel_b1;
    logic [31:0] cpu_word;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = mem_q[8*gi +: 8];
            assign store_data[8*gi +: 8] =
                (op == SW)                            ? wdata[31-8*gi -: 8] :
                (op == SB && k == 2'(gi))             ? wdata[7:0]          :
                (op == SH && k == 2'(gi))             ? wdata[15:8]         :
                (op == SH && (k + 2'd1) == 2'(gi))    ? wdata[7:0]          :
                                                        lane[gi];
        end
    endgenerate

    assign cpu_word = byte_reverse(mem_q);
    assign sel_b    = lane[k];
    assign sel_b1   = lane[k + 2'd1];

`ifdef MIPS_LSU_UNALIGNED_EN
    logic [4:0] shl;
    logic [4:0] shr;
    assign shl = {k, 3'b000};
    assign shr = {~k, 3'b000};
`else
    logic unused_rt_old;
    assign unused_rt_old = ^rt_old;
`endif

    always_comb begin
        load_data = '0;
        err       = 1'b0;
        case (op)
            LB:  load_data = {{24{sel_b[7]}}, sel_b};
            LBU: load_data = {24'd0, sel_b};
            LH: begin
                err = k[0];
                if (!k[0]) load_data = {{16{sel_b[7]}}, sel_b, sel_b1};
            end
            LHU: begin
                err = k[0];
                if (!k[0]) load_data = {16'd0, sel_b, sel_b1};
            end
            LW: begin
                err = (k != 2'd0);
                if (k == 2'd0) load_data = cpu_word;
            end
            SB:  err = 1'b0;
            SH:  err = k[0];
            SW:  err = (k != 2'd0);
`ifdef MIPS_LSU_UNALIGNED_EN
            LWL: load_data = (cpu_word << shl) | (rt_old & ((32'h1 << shl) - 32'h1));
            LWR: load_data = (cpu_word >> shr) | (rt_old & ~(32'hFFFF_FFFF >> shr));
`endif
            default: err = 1'b1;
        endcase
    end
endmodule

// File: rtl/mips_data_lsu.sv
// MIPS data-port load/store initiator: turns byte/half/word accesses into aligned
// word reads/writes with read-modify-write for SB/SH. LWL/LWR need MIPS_LSU_UNALIGNED_EN.
module mips_data_lsu
    import mips_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic            clk,
    input logic            reset,
    mips_lsu_req_if.slave  cpu,
    mips_lsu_mem_if.master mem
);
    lsu_state_t        state_q, state_d;
    lsu_op_t           op_q, op_d;
    logic [1:0]        k_q, k_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rt_old_q, rt_old_d;
    logic [DATA_W-1:0] mem_q, mem_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] data_address_q, data_address_d;
    logic              data_read_q, data_read_d;
    logic              data_write_q, data_write_d;
    logic [DATA_W-1:0] data_writedata_q, data_writedata_d;

    lsu_op_t     lane_op;
    logic [1:0]  lane_k;
    logic [31:0] lane_mem;
    logic [31:0] lane_load;
    logic [31:0] lane_store;
    logic        lane_err;

    // In IDLE the lane checks the incoming request; in RD it sees the live RAM word.
    assign lane_op  = (state_q == IDLE) ? cpu.op        : op_q;
    assign lane_k   = (state_q == IDLE) ? cpu.addr[1:0] : k_q;
    assign lane_mem = (state_q == RD)   ? mem.data_readdata : mem_q;

    mips_lsu_lane u_lane (
        .mem_q      (lane_mem),
        .op         (lane_op),
        .k          (lane_k),
        .wdata      (wdata_q),
        .rt_old     (rt_old_q),
        .load_data  (lane_load),
        .store_data (lane_store),
        .err        (lane_err)
    );

    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        k_d              = k_q;
        wdata_d          = wdata_q;
        rt_old_d         = rt_old_q;
        mem_d            = mem_q;
        err_d            = err_q;
        rdata_d          = rdata_q;
        data_address_d   = data_address_q;
        done_d           = 1'b0;
        data_read_d      = 1'b0;
        data_write_d     = 1'b0;
        data_writedata_d = '0;
        case (state_q)
            IDLE: begin
                data_address_d = '0;
                if (cpu.req) begin
                    op_d     = cpu.op;
                    k_d      = cpu.addr[1:0];
                    wdata_d  = cpu.wdata;
                    rt_old_d = cpu.rt_old;
                    err_d    = lane_err;
                    if (lane_err) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        rdata_d = '0;
                    end else if (cpu.op == SW) begin
                        state_d          = WR;
                        data_write_d     = 1'b1;
                        data_writedata_d = byte_reverse(cpu.wdata);
                        data_address_d   = {cpu.addr[ADDR_W-1:2], 2'b00};
                    end else begin
                        state_d        = RD;
                        data_read_d    = 1'b1;
                        data_address_d = {cpu.addr[ADDR_W-1:2], 2'b00};
                    end
                end
            end
            RD: begin
                mem_d = mem.data_readdata;
                if (is_rmw(op_q)) begin
                    state_d          = WR;
                    data_write_d     = 1'b1;
                    data_writedata_d = lane_store;
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    rdata_d = lane_load;
                end
            end
            WR: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            DONE: begin
                state_d        = IDLE;
                data_address_d = '0;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            op_q             <= LB;
            k_q              <= '0;
            wdata_q          <= '0;
            rt_old_q         <= '0;
            mem_q            <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            err_q            <= 1'b0;
            rdata_q          <= '0;
            data_address_q   <= '0;
            data_read_q      <= 1'b0;
            data_write_q     <= 1'b0;
            data_writedata_q <= '0;
        end else begin
            state_q          <= state_d;
            op_q             <= op_d;
            k_q              <= k_d;
            wdata_q          <= wdata_d;
            rt_old_q         <= rt_old_d;
            mem_q            <= mem_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            err_q            <= err_d;
            rdata_q          <= rdata_d;
            data_address_q   <= data_address_d;
            data_read_q      <= data_read_d;
            data_write_q     <= data_write_d;
            data_writedata_q <= data_writedata_d;
        end
    end

    assign cpu.busy           = busy_q;
    assign cpu.done           = done_q;
    assign cpu.err            = err_q;
    assign cpu.rdata          = rdata_q;
    assign mem.data_address   = data_address_q;
    assign mem.data_read      = data_read_q;
    assign mem.data_write     = data_write_q;
    assign mem.data_writedata = data_writedata_q;
endmodule

// File: tb/tb_mips_data_lsu.sv
// Scoreboard bench for mips_data_lsu against a combinational-read word RAM whose
// every word starts as CPU word 32'hABCDEF00 (memory order 32'h00EFCDAB).
module tb_mips_data_lsu;
    import mips_lsu_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        bit          chk_rdata;
        int          lat;
        int          n_rd;
        int          n_wr;
        logic [31:0] addr;
        logic [31:0] wword;
        int          req_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   done_seen = 0;
    int   rd_cnt = 0;
    int   wr_cnt = 0;
    bit   manual = 1'b0;
    exp_t sb_q[$];
    exp_t cur;
    logic [31:0] ram [64];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mips_lsu_req_if #(.ADDR_W(32)) rif ();
    mips_lsu_mem_if #(.ADDR_W(32)) mif ();

    mips_data_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .cpu   (rif),
        .mem   (mif)
    );

    assign mif.data_readdata = ram[mif.data_address[7:2]];
    always @(posedge clk) begin
        if (mif.data_write) ram[mif.data_address[7:2]] <= mif.data_writedata;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: checks every bus access and every done pulse against the queue head.
    always @(negedge clk) begin
        if (!reset && !manual) begin
            if (mif.data_read || mif.data_write) begin
                if (sb_q.size() == 0) begin
                    check("stray_access", 1'b1, 1'b0);
                end else begin
                    cur = sb_q[0];
                    if (mif.data_read) rd_cnt++;
                    if (mif.data_write) begin
                        wr_cnt++;
                        check({cur.name, "_wword"}, mif.data_writedata, cur.wword);
                    end
                    check({cur.name, "_addr"}, mif.data_address, cur.addr);
                end
            end
            if (rif.done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 1'b1, 1'b0);
                end else begin
                    cur = sb_q.pop_front();
                    check({cur.name, "_err"}, rif.err, cur.err);
                    if (cur.chk_rdata) check({cur.name, "_rdata"}, rif.rdata, cur.rdata);
                    check({cur.name, "_latency"}, 32'(cyc - cur.req_cyc), 32'(cur.lat));
                    check({cur.name, "_reads"}, 32'(rd_cnt), 32'(cur.n_rd));
                    check({cur.name, "_writes"}, 32'(wr_cnt), 32'(cur.n_wr));
                    $display("txn %s: rdata=%08h err=%0b latency=%0d rd=%0d wr=%0d",
                             cur.name, rif.rdata, rif.err, cyc - cur.req_cyc, rd_cnt, wr_cnt);
                end
                rd_cnt = 0;
                wr_cnt = 0;
                done_seen++;
            end
        end
    end

    task automatic wait_idle();
        int b;
        b = 0;
        @(negedge clk);
        while ((rif.busy || rif.done) && b < 50) begin
            @(negedge clk);
            b++;
        end
        if (b >= 50) check("idle_timeout", 1'b1, 1'b0);
    endtask

    task automatic run(input string name, input lsu_op_t op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rt_old,
                       input logic [31:0] exp_rdata, input logic exp_err, input bit chk,
                       input int lat, input int n_rd, input int n_wr, input logic [31:0] wword);
        exp_t e;
        int   target;
        int   b;
        wait_idle();
        e.name = name; e.rdata = exp_rdata; e.err = exp_err; e.chk_rdata = chk;
        e.lat = lat; e.n_rd = n_rd; e.n_wr = n_wr; e.addr = {addr[31:2], 2'b00};
        e.wword = wword; e.req_cyc = cyc;
        sb_q.push_back(e);
        target     = done_seen + 1;
        rif.req    = 1'b1;
        rif.op     = op;
        rif.addr   = addr;
        rif.wdata  = wdata;
        rif.rt_old = rt_old;
        @(negedge clk);
        rif.req = 1'b0;
        b = 0;
        while (done_seen < target && b < 20) begin
            @(negedge clk);
            b++;
        end
        if (done_seen < target) check({name, "_done_timeout"}, 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 32'h00EF_CDAB;
        reset      = 1'b1;
        rif.req    = 1'b0;
        rif.op     = LB;
        rif.addr   = '0;
        rif.wdata  = '0;
        rif.rt_old = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {rif.busy, rif.done, rif.err, rif.rdata, mif.data_address,
                                mif.data_read, mif.data_write, mif.data_writedata}, '0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_outputs", {rif.busy, rif.done, mif.data_address, mif.data_read, mif.data_write}, '0);

        run("lw_10",   LW,  32'h10, 0, 0, 32'hABCDEF00, 0, 1, 2, 1, 0, 0);
        run("lb_11",   LB,  32'h11, 0, 0, 32'hFFFFFFCD, 0, 1, 2, 1, 0, 0);
        run("lbu_11",  LBU, 32'h11, 0, 0, 32'h000000CD, 0, 1, 2, 1, 0, 0);
        run("lhu_12",  LHU, 32'h12, 0, 0, 32'h0000EF00, 0, 1, 2, 1, 0, 0);
        run("lh_12",   LH,  32'h12, 0, 0, 32'hFFFFEF00, 0, 1, 2, 1, 0, 0);
        run("sb_22",   SB,  32'h22, 32'h7E, 0, 0, 0, 0, 3, 1, 1, 32'h007ECDAB);
        run("lw_20",   LW,  32'h20, 0, 0, 32'hABCD7E00, 0, 1, 2, 1, 0, 0);
        run("sh_13",   SH,  32'h13, 32'hBEEF, 0, 32'h0, 1, 1, 1, 0, 0, 0);
        run("sw_30",   SW,  32'h30, 32'h01020304, 0, 0, 0, 0, 2, 0, 1, 32'h04030201);
        run("lw_30",   LW,  32'h30, 0, 0, 32'h01020304, 0, 1, 2, 1, 0, 0);
        run("lb_33",   LB,  32'h33, 0, 0, 32'h00000004, 0, 1, 2, 1, 0, 0);
        run("sh_2a",   SH,  32'h2A, 32'h1234, 0, 0, 0, 0, 3, 1, 1, 32'h3412CDAB);
        run("lw_28",   LW,  32'h28, 0, 0, 32'hABCD1234, 0, 1, 2, 1, 0, 0);
        run("lw_31",   LW,  32'h31, 0, 0, 32'h0, 1, 1, 1, 0, 0, 0);
        run("lhu_2b",  LHU, 32'h2B, 0, 0, 32'h0, 1, 1, 1, 0, 0, 0);
        run("lbu_2b",  LBU, 32'h2B, 0, 0, 32'h00000034, 0, 1, 2, 1, 0, 0);
        run("op_12",   lsu_op_t'(4'd12), 32'h10, 0, 0, 32'h0, 1, 1, 1, 0, 0, 0);

        // Reset lands in the WR cycle of SW 0x40: the write must never reach the RAM.
        wait_idle();
        manual     = 1'b1;
        rif.req    = 1'b1;
        rif.op     = SW;
        rif.addr   = 32'h40;
        rif.wdata  = 32'h0;
        rif.rt_old = 32'h0;
        @(negedge clk);
        rif.req = 1'b0;
        check("rst_wr_cycle", {mif.data_write, mif.data_read, mif.data_address}, {1'b1, 1'b0, 32'h40});
        reset = 1'b1;
        #1;
        check("rst_mid_wr_outputs", {rif.busy, rif.done, rif.err, rif.rdata, mif.data_address,
                                     mif.data_read, mif.data_write, mif.data_writedata}, '0);
        @(negedge clk);
        reset  = 1'b0;
        manual = 1'b0;
        $display("txn rst_sw_40: reset during WR cycle");
        run("lw_40",   LW,  32'h40, 0, 0, 32'hABCDEF00, 0, 1, 2, 1, 0, 0);

`ifdef MIPS_LSU_UNALIGNED_EN
        run("lwl_05",  LWL, 32'h05, 0, 32'h11223344, 32'hCDEF0044, 0, 1, 2, 1, 0, 0);
        run("lwr_05",  LWR, 32'h05, 0, 32'h11223344, 32'h1122ABCD, 0, 1, 2, 1, 0, 0);
        run("lwl_07",  LWL, 32'h07, 0, 32'h11223344, 32'h00223344, 0, 1, 2, 1, 0, 0);
`else
        run("lwl_05",  LWL, 32'h05, 0, 32'h11223344, 32'h0, 1, 1, 1, 0, 0, 0);
        run("lwr_05",  LWR, 32'h05, 0, 32'h11223344, 32'h0, 1, 1, 1, 0, 0, 0);
`endif
        run("lw_14",   LW,  32'h14, 0, 0, 32'hABCDEF00, 0, 1, 2, 1, 0, 0);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
